// File: rtl/conmutador_baterias.sv
`default_nettype none
// ============================================================================
//  Module      : conmutador_baterias
//  Description : Debounces the two battery-discharge warnings, selects the
//                battery that powers the load (B1 / B2 / critical FSM),
//                drives a blinking warning LED, an acknowledgeable critical
//                buzzer and a saturating switchover counter.
//  Revision    : 1.0  initial release
// ============================================================================
module conmutador_baterias #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int BLINK_HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advertencia_bateria_1,
  input  logic       advertencia_bateria_2,
  input  logic       ack_alarma,
  output logic       advertencia_estable_1,
  output logic       advertencia_estable_2,
  output logic       bateria_activa,
  output logic       led_alarma,
  output logic       zumbador,
  output logic [7:0] contador_cambios
);

  localparam logic [3:0] C_DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    S_B1   = 2'd0,
    S_B2   = 2'd1,
    S_CRIT = 2'd2
  } state_t;

  // Raw warnings packed by channel: bit 0 = battery 1, bit 1 = battery 2
  logic [1:0] raw_w;
  assign raw_w = {advertencia_bateria_2, advertencia_bateria_1};

  logic [1:0] estable_q;
  logic [3:0] deb_cnt_q [2];

  // Per-channel debounce: a new value must persist DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estable_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_w[i] != estable_q[i]) begin
          if (deb_cnt_q[i] == C_DEB_LAST) begin
            estable_q[i] <= raw_w[i];
            deb_cnt_q[i] <= 4'd0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 4'd1;
          end
        end else begin
          deb_cnt_q[i] <= 4'd0;
        end
      end
    end
  end

  logic d1_w;
  logic d2_w;
  assign d1_w = estable_q[0];
  assign d2_w = estable_q[1];

  state_t     state_q;
  state_t     state_d;
  logic       silenciado_q;
  logic       silenciado_d;
  logic       switch_w;
  logic       bateria_q;
  logic       zumbador_q;
  logic [7:0] contador_q;

  // Next-state, silence flag and switchover detection from the debounced flags
  always_comb begin
    state_d      = state_q;
    silenciado_d = 1'b0;
    switch_w     = 1'b0;
    case (state_q)
      S_B1: begin
        if (d1_w && d2_w) begin
          state_d = S_CRIT;
        end else if (d1_w) begin
          state_d  = S_B2;
          switch_w = 1'b1;
        end
      end
      S_B2: begin
        if (d1_w && d2_w) begin
          state_d = S_CRIT;
        end else if (d2_w) begin
          state_d  = S_B1;
          switch_w = 1'b1;
        end
      end
      S_CRIT: begin
        // Battery 1 wins when both recover on the same edge
        if (!d1_w) begin
          state_d = S_B1;
        end else if (!d2_w) begin
          state_d = S_B2;
        end else begin
          silenciado_d = silenciado_q | ack_alarma;
        end
      end
      default: state_d = S_B1;
    endcase
  end

  // State register with registered battery select, buzzer and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_B1;
      silenciado_q <= 1'b0;
      bateria_q    <= 1'b0;
      zumbador_q   <= 1'b0;
      contador_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      silenciado_q <= silenciado_d;
      zumbador_q   <= (state_d == S_CRIT) && !silenciado_d;
      case (state_d)
        S_B1:    bateria_q <= 1'b0;
        S_B2:    bateria_q <= 1'b1;
        default: bateria_q <= bateria_q;
      endcase
      if (switch_w && (contador_q != 8'hFF)) begin
        contador_q <= contador_q + 8'd1;
      end
    end
  end

  logic       en_w;
  logic       led_q;
  logic       led_activo_q;
  logic [7:0] blink_cnt_q;
  assign en_w = d1_w | d2_w;

  // LED blinker: starts lit, toggles every BLINK_HALF_PERIOD cycles while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q        <= 1'b0;
      led_activo_q <= 1'b0;
      blink_cnt_q  <= 8'd0;
    end else if (!en_w) begin
      led_q        <= 1'b0;
      led_activo_q <= 1'b0;
      blink_cnt_q  <= 8'd0;
    end else if (!led_activo_q) begin
      led_q        <= 1'b1;
      led_activo_q <= 1'b1;
      blink_cnt_q  <= 8'd0;
    end else if (blink_cnt_q == C_BLINK_LAST) begin
      led_q       <= ~led_q;
      blink_cnt_q <= 8'd0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 8'd1;
    end
  end

  assign advertencia_estable_1 = estable_q[0];
  assign advertencia_estable_2 = estable_q[1];
  assign bateria_activa        = bateria_q;
  assign led_alarma            = led_q;
  assign zumbador              = zumbador_q;
  assign contador_cambios      = contador_q;

endmodule
`default_nettype wire

// File: tb/tb_conmutador_baterias.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conmutador_baterias
//  Description : Directed self-checking bench for conmutador_baterias.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conmutador_baterias;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       adv1 = 1'b0;
  logic       adv2 = 1'b0;
  logic       ack = 1'b0;
  logic       est1;
  logic       est2;
  logic       bat;
  logic       led;
  logic       zum;
  logic [7:0] cnt;

  int n_pass  = 0;
  int n_total = 0;

  conmutador_baterias #(
    .DEBOUNCE_CYCLES  (4),
    .BLINK_HALF_PERIOD(8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .advertencia_bateria_1(adv1),
    .advertencia_bateria_2(adv2),
    .ack_alarma           (ack),
    .advertencia_estable_1(est1),
    .advertencia_estable_2(est2),
    .bateria_activa       (bat),
    .led_alarma           (led),
    .zumbador             (zum),
    .contador_cambios     (cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    n_total++;
    if ({est1, est2, bat, led, zum, cnt} !== 13'd0) $display("FAIL reset_in: outputs got %b expected 0", {est1, est2, bat, led, zum, cnt});
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    step(20);
    n_total++;
    if ({est1, est2, led, zum} !== 4'd0) $display("FAIL idle_flags: got %b expected 0000", {est1, est2, led, zum});
    else n_pass++;
    n_total++;
    if (bat !== 1'b0) $display("FAIL idle_bat: got %0d expected 0", bat);
    else n_pass++;
    n_total++;
    if (cnt !== 8'd0) $display("FAIL idle_cnt: got %0d expected 0", cnt);
    else n_pass++;
  endtask

  task automatic test_glitch();
    adv1 = 1'b1;
    step(3);
    adv1 = 1'b0;
    step(5);
    n_total++;
    if (est1 !== 1'b0) $display("FAIL glitch_est1: got %0d expected 0", est1);
    else n_pass++;
    n_total++;
    if (bat !== 1'b0 || led !== 1'b0) $display("FAIL glitch_bat_led: got %0d%0d expected 00", bat, led);
    else n_pass++;
  endtask

  task automatic test_switch();
    adv1 = 1'b1;
    step(3);
    n_total++;
    if (est1 !== 1'b0) $display("FAIL sw_est1_e3: got %0d expected 0", est1);
    else n_pass++;
    step(1);
    n_total++;
    if (est1 !== 1'b1 || bat !== 1'b0) $display("FAIL sw_e4: est1/bat got %0d%0d expected 10", est1, bat);
    else n_pass++;
    step(1);
    n_total++;
    if (bat !== 1'b1) $display("FAIL sw_bat_e5: got %0d expected 1", bat);
    else n_pass++;
    n_total++;
    if (cnt !== 8'd1) $display("FAIL sw_cnt: got %0d expected 1", cnt);
    else n_pass++;
    n_total++;
    if (led !== 1'b1) $display("FAIL sw_led_k0: got %0d expected 1", led);
    else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      n_total++;
      if (led !== (((k / 8) % 2) == 0)) $display("FAIL led_blink k=%0d: got %0d expected %0d", k, led, ((k / 8) % 2) == 0);
      else n_pass++;
    end
  endtask

  task automatic test_crit();
    adv2 = 1'b1;
    step(4);
    n_total++;
    if (est2 !== 1'b1 || zum !== 1'b0) $display("FAIL crit_e4: est2/zum got %0d%0d expected 10", est2, zum);
    else n_pass++;
    step(1);
    n_total++;
    if (zum !== 1'b1 || bat !== 1'b1) $display("FAIL crit_e5: zum/bat got %0d%0d expected 11", zum, bat);
    else n_pass++;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_total++;
    if (zum !== 1'b0) $display("FAIL ack_drop: got %0d expected 0", zum);
    else n_pass++;
    step(5);
    n_total++;
    if (zum !== 1'b0) $display("FAIL ack_hold: got %0d expected 0", zum);
    else n_pass++;
    adv2 = 1'b0;
    step(5);
    n_total++;
    if (bat !== 1'b1 || zum !== 1'b0 || cnt !== 8'd1) $display("FAIL crit_to_b2: bat/zum/cnt got %0d/%0d/%0d expected 1/0/1", bat, zum, cnt);
    else n_pass++;
    adv2 = 1'b1;
    step(5);
    n_total++;
    if (zum !== 1'b1) $display("FAIL crit_reenter: got %0d expected 1", zum);
    else n_pass++;
  endtask

  task automatic test_both_drop();
    adv1 = 1'b0;
    adv2 = 1'b0;
    step(4);
    n_total++;
    if (est1 !== 1'b0 || est2 !== 1'b0 || bat !== 1'b1) $display("FAIL drop_e4: est1/est2/bat got %0d%0d%0d expected 001", est1, est2, bat);
    else n_pass++;
    step(1);
    n_total++;
    if (bat !== 1'b0 || zum !== 1'b0 || led !== 1'b0) $display("FAIL drop_e5: bat/zum/led got %0d%0d%0d expected 000", bat, zum, led);
    else n_pass++;
    n_total++;
    if (cnt !== 8'd1) $display("FAIL drop_cnt: got %0d expected 1", cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 301; n++) begin
      adv1 = (n % 2) == 1;
      adv2 = (n % 2) == 0;
      step(5);
      if (n == 253 || n == 254 || n == 301) begin
        n_total++;
        if (cnt !== ((n + 1 > 255) ? 8'd255 : 8'(n + 1))) $display("FAIL sat_cnt n=%0d: got %0d expected %0d", n, cnt, (n + 1 > 255) ? 255 : n + 1);
        else n_pass++;
      end
    end
    n_total++;
    if (bat !== 1'b1) $display("FAIL sat_bat: got %0d expected 1", bat);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    adv1 = 1'b0;
    adv2 = 1'b1;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({est1, est2, bat, led, zum} !== 5'd0) $display("FAIL arst_flags: got %b expected 00000", {est1, est2, bat, led, zum});
    else n_pass++;
    n_total++;
    if (cnt !== 8'd0) $display("FAIL arst_cnt: got %0d expected 0", cnt);
    else n_pass++;
    #1 rst_n = 1'b1;
    step(3);
    n_total++;
    if (est2 !== 1'b0) $display("FAIL arst_deb_e3: got %0d expected 0", est2);
    else n_pass++;
    step(1);
    n_total++;
    if (est2 !== 1'b1) $display("FAIL arst_deb_e4: got %0d expected 1", est2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_switch();
    test_crit();
    test_both_drop();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
